sc_et_sequencer: RTL and testbench

Run controller for one early-terminated stochastic-computing (SC) evaluation. It converts a binary operand into a bitstream with an 8-bit LFSR and a comparator, and drives that stream into the external SC datapath. It counts the datapath's output ones and stops the run either when the variable early-termination detector asserts its done signal or when a programmed maximum length is reached. It then reports the count, the stream length, and the reason for termination.

---
 rtl/sc_et_sequencer.sv | 130 +++++++++++++
 tb/tb_sc_et_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sc_et_sequencer.sv
// sc_et_sequencer: runs one early-terminated stochastic-computing evaluation.
// An 8-bit LFSR and a comparator turn the operand into a bitstream. Ones on the
// datapath result are counted until the ET detector fires or the programmed
// length is reached. Count, length and termination reason are then held for the host.
module sc_et_sequencer #(
  parameter logic [7:0] SEED      = 8'h01,
  parameter int         CNT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           x,
  input  logic [CNT_WIDTH-1:0] max_len,
  output logic                 sx,
  output logic                 sc_valid,
  input  logic                 z,
  input  logic                 et_done,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] ones,
  output logic [CNT_WIDTH-1:0] len,
  output logic                 early
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // One step of the maximal-length Fibonacci LFSR (taps 8,6,5,4).
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [7:0]           x_q, x_d;
  logic [CNT_WIDTH-1:0] max_len_q, max_len_d;
  logic [CNT_WIDTH-1:0] ones_q, ones_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 early_q, early_d;
  logic [CNT_WIDTH-1:0] len_inc_s;

  assign len_inc_s = len_q + CNT_ONE;

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    x_d       = x_q;
    max_len_d = max_len_q;
    ones_d    = ones_q;
    len_d     = len_q;
    early_d   = early_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = x;
          max_len_d = max_len;
          lfsr_d    = SEED;
          ones_d    = CNT_ZERO;
          len_d     = CNT_ZERO;
          early_d   = 1'b0;
          // A zero-length request skips RUN entirely.
          if (max_len == CNT_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        len_d  = len_inc_s;
        ones_d = ones_q + {{(CNT_WIDTH-1){1'b0}}, z};
        lfsr_d = lfsr_step(lfsr_q);
        // The current cycle's z is already counted above in both exit cases.
        if (et_done || (len_inc_s == max_len_q)) begin
          state_d = S_DONE;
          early_d = et_done;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state and run registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      x_q       <= 8'h00;
      max_len_q <= CNT_ZERO;
      ones_q    <= CNT_ZERO;
      len_q     <= CNT_ZERO;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      x_q       <= x_d;
      max_len_q <= max_len_d;
      ones_q    <= ones_d;
      len_q     <= len_d;
      early_q   <= early_d;
    end
  end

  // Status decodes come straight from the state register. The stochastic bit
  // must reflect the current LFSR value so the datapath can respond in the same cycle.
  assign sc_valid = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign sx       = (state_q == S_RUN) && (lfsr_q < x_q);
  assign ones     = ones_q;
  assign len      = len_q;
  assign early    = early_q;

endmodule

// File: tb/tb_sc_et_sequencer.sv
// tb_sc_et_sequencer: directed and randomized runs of sc_et_sequencer.
// Expected results are computed by a reference model inside the bench.
module tb_sc_et_sequencer;
  localparam int         CW   = 9;
  localparam logic [7:0] SEED = 8'h01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    x = 8'h00;
  logic [CW-1:0] max_len = '0;
  logic          z;
  logic          et_done = 1'b0;
  logic          zmode = 1'b0;
  logic          zconst = 1'b0;
  logic          sx, sc_valid, busy, done, early;
  logic [CW-1:0] ones, len;

  int checks = 0;
  int errors = 0;

  sc_et_sequencer #(.SEED(SEED), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .max_len(max_len),
    .sx(sx), .sc_valid(sc_valid), .z(z), .et_done(et_done),
    .busy(busy), .done(done), .ones(ones), .len(len), .early(early)
  );

  // Datapath stand-in: either a constant or a wire straight from sx.
  assign z = zmode ? sx : zconst;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] next_lfsr(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_sx"}, {31'd0, sx}, 32'd0);
    check({tag, "_valid"}, {31'd0, sc_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_ones"}, {23'd0, ones}, 32'd0);
    check({tag, "_len"}, {23'd0, len}, 32'd0);
    check({tag, "_early"}, {31'd0, early}, 32'd0);
  endtask

  // One run: model the expected outcome, drive it, compare.
  // et_at: RUN cycle index (0-based) carrying et_done, -1 none.
  // noise: extra start pulses during RUN and DONE. abort_at: RUN cycle to drop rst_n, -1 none.
  task automatic run_case(input string tag, input logic [7:0] xv, input int ml, input bit zm,
                          input bit zc, input int et_at, input bit noise, input int abort_at);
    int exp_len, exp_ones, k;
    bit exp_early;
    logic [7:0] l;
    exp_len = 0; exp_ones = 0; exp_early = 1'b0; l = SEED;
    for (int i = 0; i < ml; i++) begin
      bit s;
      s = (l < xv);
      exp_ones += (zm ? int'(s) : int'(zc));
      exp_len = i + 1;
      if (i == et_at) begin
        exp_early = 1'b1;
        break;
      end
      l = next_lfsr(l);
    end

    @(negedge clk);
    x = xv; max_len = ml[CW-1:0]; zmode = zm; zconst = zc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom);
    max_len = CW'($urandom);
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);

    l = SEED; k = 0;
    while (sc_valid === 1'b1 && k < ml + 2) begin
      check({tag, "_sx"}, {31'd0, sx}, {31'd0, (l < xv)});
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_values({tag, "_abort"});
        @(negedge clk);
        check({tag, "_abort_nodone"}, {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_abort_idle"}, {31'd0, busy}, 32'd0);
        return;
      end
      et_done = (k == et_at);
      if (noise) start = 1'($urandom_range(0, 1));
      k++;
      l = next_lfsr(l);
      @(negedge clk);
      et_done = 1'b0;
      start = 1'b0;
    end

    check({tag, "_valid_cycles"}, k, exp_len);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_len"}, {23'd0, len}, exp_len);
    check({tag, "_ones"}, {23'd0, ones}, exp_ones);
    check({tag, "_early"}, {31'd0, early}, {31'd0, exp_early});
    if (noise) begin
      start = 1'b1;
      et_done = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    et_done = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_len_held"}, {23'd0, len}, exp_len);
    check({tag, "_ones_held"}, {23'd0, ones}, exp_ones);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle_after_reset");

    run_case("z1_len20", 8'h80, 20, 1'b0, 1'b1, -1, 1'b0, -1);
    run_case("half_255a", 8'h80, 255, 1'b1, 1'b0, -1, 1'b0, -1);
    check("half_255a_const", {23'd0, ones}, 32'd127);
    run_case("half_255b", 8'h80, 255, 1'b1, 1'b0, -1, 1'b0, -1);
    check("half_255b_const", {23'd0, ones}, 32'd127);
    run_case("x0_len50", 8'h00, 50, 1'b1, 1'b0, -1, 1'b0, -1);
    run_case("et_5th", 8'h80, 100, 1'b0, 1'b1, 4, 1'b0, -1);
    run_case("et_last", 8'h80, 5, 1'b0, 1'b1, 4, 1'b0, -1);
    run_case("len0", 8'h55, 0, 1'b0, 1'b1, -1, 1'b0, -1);
    run_case("noise", 8'hC3, 30, 1'b1, 1'b0, -1, 1'b1, -1);
    run_case("abort", 8'h80, 100, 1'b0, 1'b1, -1, 1'b0, 2);
    run_case("after_abort", 8'h40, 12, 1'b1, 1'b0, -1, 1'b0, -1);
    run_case("wrap_300", 8'hA0, 300, 1'b1, 1'b0, -1, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      int ml, et;
      ml = $urandom_range(0, 300);
      et = ($urandom_range(0, 1) == 1) ? $urandom_range(0, ml + 3) : -1;
      run_case("rand", 8'($urandom), ml, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               et, 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
